// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway in front of the PLIC.
// Synchronises raw interrupt lines, applies level or rising-edge semantics
// per source, and allows at most one outstanding request per source until
// the PLIC claims it and the hart completes it. Edge sources queue pulses
// that arrive while a request is outstanding in a saturating counter.
module plic_gateway #(
    parameter int SOURCES     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_CNT_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SOURCES-1:0] irq_in,
    input  logic [SOURCES-1:0] irq_edge_mode,
    input  logic               claim_valid,
    input  logic [4:0]         claim_id,
    input  logic               complete_valid,
    input  logic [4:0]         complete_id,
    output logic [SOURCES-1:0] gateway_req,
    output logic [SOURCES-1:0] edge_overflow
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REQ      = 2'd1;
    localparam logic [1:0] ST_INFLIGHT = 2'd2;

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

    // Source 0 is reserved, so every per-source vector starts at bit 1.
    logic [SOURCES-1:1] sync_q [SYNC_STAGES];
    logic [SOURCES-1:1] prev_q;
    logic [SOURCES-1:1] sync_s;
    logic [SOURCES-1:1] rise;
    logic [SOURCES-1:1] claim_hit;
    logic [SOURCES-1:1] complete_hit;

    // Bit 0 of the inputs is deliberately ignored.
    logic unused_bit0;
    assign unused_bit0 = irq_in[0] ^ irq_edge_mode[0];

    // Multi-flop synchroniser per line plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in[SOURCES-1:1];
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_s;
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign rise   = sync_s & ~prev_q;

    // Decode claim/complete IDs; IDs of 0 or beyond the last source never match.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 1; i < SOURCES; i++) begin
            claim_hit[i]    = claim_valid    && (32'(claim_id)    == i);
            complete_hit[i] = complete_valid && (32'(complete_id) == i);
        end
    end

    assign gateway_req[0]   = 1'b0;
    assign edge_overflow[0] = 1'b0;

    for (genvar i = 1; i < SOURCES; i++) begin : g_src
        logic [1:0]            state_q;
        logic [1:0]            state_d;
        logic [EDGE_CNT_W-1:0] cnt_q;
        logic [EDGE_CNT_W-1:0] cnt_d;
        logic                  req_q;
        logic                  ovf_q;
        logic                  ovf_d;
        logic                  edge_mode;
        logic                  trig;
        logic                  take;

        // Next-state and edge-counter logic; a rise that starts a request is consumed directly.
        always_comb begin
            edge_mode = irq_edge_mode[i];
            trig      = edge_mode ? ((cnt_q != '0) || rise[i]) : sync_s[i];
            take      = (state_q == ST_IDLE) && trig;

            state_d = state_q;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (claim_hit[i]) begin
                        state_d = ST_INFLIGHT;
                    end else if (!edge_mode && !sync_s[i]) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_INFLIGHT: begin
                    if (complete_hit[i]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (!edge_mode) begin
                cnt_d = '0;
            end else if (rise[i] && !take) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else if (take && !rise[i]) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        // Per-source state, counter, registered request and sticky overflow flag.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                req_q   <= (state_d == ST_REQ);
                ovf_q   <= ovf_d;
            end
        end

        assign gateway_req[i]   = req_q;
        assign edge_overflow[i] = ovf_q;
    end

endmodule

// File: tb/tb_plic_gateway.sv
// tb_plic_gateway: directed scenarios for plic_gateway. Expected output
// values are queued with the cycle they must appear in and compared by a
// monitor on the falling edge of that cycle.
module tb_plic_gateway;

    localparam int SOURCES = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [SOURCES-1:0] irq_in;
    logic [SOURCES-1:0] irq_edge_mode;
    logic               claim_valid;
    logic [4:0]         claim_id;
    logic               complete_valid;
    logic [4:0]         complete_id;
    logic [SOURCES-1:0] gateway_req;
    logic [SOURCES-1:0] edge_overflow;

    plic_gateway #(
        .SOURCES(SOURCES),
        .SYNC_STAGES(2),
        .EDGE_CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_in(irq_in),
        .irq_edge_mode(irq_edge_mode),
        .claim_valid(claim_valid),
        .claim_id(claim_id),
        .complete_valid(complete_valid),
        .complete_id(complete_id),
        .gateway_req(gateway_req),
        .edge_overflow(edge_overflow)
    );

    // Kinds: 0 = one gateway_req bit, 1 = one edge_overflow bit,
    // 2 = whole gateway_req vector, 3 = whole edge_overflow vector.
    typedef struct {
        int          cyc;
        int          kind;
        int          src;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_obs;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter: after the Nth rising edge cyc equals N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int at, input int kind, input int src, input logic [31:0] val);
        exp_t e;
        int   idx;
        e.cyc  = at;
        e.kind = kind;
        e.src  = src;
        e.val  = val;
        idx    = sb.size();
        while (idx > 0 && sb[idx-1].cyc > at) idx--;
        sb.insert(idx, e);
    endtask

    task automatic exp_req(input int from, input int to, input int src, input logic v);
        for (int c = from; c <= to; c++) push_exp(c, 0, src, {31'b0, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    task automatic applyStimulus(input int at, input logic cv, input int cid, input logic kv, input int kid);
        wait_until(at);
        claim_valid    = cv;
        claim_id       = 5'(cid);
        complete_valid = kv;
        complete_id    = 5'(kid);
        step();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
    endtask

    task automatic set_irq(input int at, input int src, input logic v);
        wait_until(at);
        irq_in[src] = v;
    endtask

    task automatic pulse(input int at, input int src);
        set_irq(at, src, 1'b1);
        step();
        irq_in[src] = 1'b0;
    endtask

    // Monitor: compare every queued expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc) begin
                checkOutput("stale_expectation", cyc, mon_e.cyc);
            end else begin
                case (mon_e.kind)
                    0:       mon_obs = {31'b0, gateway_req[mon_e.src]};
                    1:       mon_obs = {31'b0, edge_overflow[mon_e.src]};
                    2:       mon_obs = gateway_req;
                    default: mon_obs = edge_overflow;
                endcase
                checkOutput($sformatf("kind%0d_src%0d_c%0d", mon_e.kind, mon_e.src, cyc),
                            mon_obs, mon_e.val);
            end
        end
    end

    // Stimulus: reset, then the directed scenarios in sequence.
    initial begin
        int c;
        rst            = 1'b1;
        irq_in         = '0;
        irq_edge_mode  = 32'h0000_0280;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;

        push_exp(3, 2, 0, 32'h0);
        push_exp(3, 3, 0, 32'h0);
        wait_until(3);
        rst = 1'b0;

        // Level source 3: latency, claim, re-request after completion.
        exp_req(12, 12, 3, 1'b0);
        exp_req(13, 15, 3, 1'b1);
        push_exp(13, 2, 0, 32'h0000_0008);
        exp_req(16, 21, 3, 1'b0);
        exp_req(22, 23, 3, 1'b1);
        exp_req(24, 30, 3, 1'b0);
        set_irq(10, 3, 1'b1);
        applyStimulus(15, 1'b1, 3, 1'b0, 0);
        applyStimulus(20, 1'b0, 0, 1'b1, 3);
        set_irq(23, 3, 1'b0);
        applyStimulus(23, 1'b1, 3, 1'b0, 0);
        applyStimulus(25, 1'b0, 0, 1'b1, 3);

        // Level source 5: retraction, ignored claim while IDLE, fresh request.
        exp_req(37, 37, 5, 1'b0);
        exp_req(38, 41, 5, 1'b1);
        exp_req(42, 47, 5, 1'b0);
        exp_req(48, 50, 5, 1'b1);
        exp_req(51, 52, 5, 1'b0);
        set_irq(35, 5, 1'b1);
        set_irq(39, 5, 1'b0);
        applyStimulus(44, 1'b1, 5, 1'b0, 0);
        set_irq(45, 5, 1'b1);
        set_irq(48, 5, 1'b0);

        // Edge source 7: five pulses queued while INFLIGHT give five more requests.
        exp_req(62, 62, 7, 1'b0);
        exp_req(63, 64, 7, 1'b1);
        exp_req(65, 83, 7, 1'b0);
        pulse(60, 7);
        applyStimulus(64, 1'b1, 7, 1'b0, 0);
        for (int j = 0; j < 5; j++) pulse(65 + 3 * j, 7);
        c = 83;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                exp_req(c + 1, c + 1, 7, 1'b0);
                exp_req(c + 2, c + 2, 7, 1'b1);
                exp_req(c + 3, c + 3, 7, 1'b0);
            end else begin
                exp_req(c + 1, c + 6, 7, 1'b0);
            end
            applyStimulus(c, 1'b0, 0, 1'b1, 7);
            if (k < 5) applyStimulus(c + 2, 1'b1, 7, 1'b0, 0);
            c = c + 3;
        end

        // Edge source 9: nine pulses saturate the counter and set the sticky flag.
        push_exp(112, 1, 9, 32'h0);
        exp_req(113, 114, 9, 1'b1);
        exp_req(115, 145, 9, 1'b0);
        push_exp(138, 1, 9, 32'h0);
        push_exp(139, 1, 9, 32'h1);
        pulse(110, 9);
        applyStimulus(114, 1'b1, 9, 1'b0, 0);
        for (int j = 0; j < 9; j++) pulse(115 + 3 * j, 9);
        c = 145;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                exp_req(c + 1, c + 1, 9, 1'b0);
                exp_req(c + 2, c + 2, 9, 1'b1);
                exp_req(c + 3, c + 3, 9, 1'b0);
            end else begin
                exp_req(c + 1, c + 6, 9, 1'b0);
            end
            applyStimulus(c, 1'b0, 0, 1'b1, 9);
            if (k < 7) applyStimulus(c + 2, 1'b1, 9, 1'b0, 0);
            c = c + 3;
        end
        push_exp(172, 3, 0, 32'h0000_0200);

        // Level source 4: simultaneous claim+complete, stray completion for idle source 6.
        exp_req(183, 184, 4, 1'b1);
        exp_req(185, 190, 4, 1'b0);
        push_exp(187, 2, 0, 32'h0);
        push_exp(188, 2, 0, 32'h0);
        exp_req(191, 192, 4, 1'b1);
        exp_req(193, 193, 4, 1'b0);
        set_irq(180, 4, 1'b1);
        applyStimulus(184, 1'b1, 4, 1'b1, 4);
        applyStimulus(186, 1'b0, 0, 1'b1, 6);
        applyStimulus(189, 1'b0, 0, 1'b1, 4);
        applyStimulus(192, 1'b1, 4, 1'b0, 0);

        // Reset mid-operation with sources in REQ, INFLIGHT and holding counts.
        exp_req(203, 204, 3, 1'b1);
        exp_req(205, 205, 3, 1'b0);
        exp_req(203, 205, 7, 1'b1);
        exp_req(206, 206, 7, 1'b0);
        exp_req(206, 206, 4, 1'b0);
        exp_req(207, 207, 4, 1'b1);
        push_exp(219, 2, 0, 32'h0000_0014);
        push_exp(219, 3, 0, 32'h0000_0200);
        push_exp(221, 3, 0, 32'h0);
        for (int t = 221; t <= 235; t++) push_exp(t, 2, 0, 32'h0);
        push_exp(236, 2, 0, 32'h0000_0080);
        set_irq(200, 2, 1'b1);
        set_irq(200, 3, 1'b1);
        pulse(200, 7);
        applyStimulus(204, 1'b1, 3, 1'b0, 0);
        applyStimulus(205, 1'b1, 7, 1'b1, 4);
        for (int j = 0; j < 4; j++) pulse(206 + 3 * j, 7);
        wait_until(220);
        rst       = 1'b1;
        irq_in[2] = 1'b0;
        irq_in[3] = 1'b0;
        irq_in[4] = 1'b0;
        step();
        rst = 1'b0;
        pulse(233, 7);

        wait_until(240);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checkOutput("undrained_expectation", cyc, mon_e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source interrupt gateway sitting directly upstream of the PLIC; its gateway_req output drives the PLIC global_interrupts input.
- Synchronises raw device interrupt lines and applies level or edge semantics per source.
- Forwards at most one outstanding request per source; holds off re-requests until the PLIC claims and the hart completes that source.
- Counts queued edges so rapid edge pulses are not lost.

Parameters:
- SOURCES, 32, number of interrupt lines; source 0 is reserved and never requests.
- SYNC_STAGES, 2, flip-flop synchroniser depth per line; minimum 2.
- EDGE_CNT_W, 3, width of the per-source pending-edge counter; saturates at 2^EDGE_CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  SOURCES  raw asynchronous interrupt lines from peripherals.
- irq_edge_mode  in  SOURCES  per-source mode: 1 = rising-edge triggered, 0 = level (high) triggered.
- claim_valid  in  1  one-cycle pulse: PLIC has handed source claim_id to a hart.
- claim_id  in  5  ID being claimed.
- complete_valid  in  1  one-cycle pulse: hart wrote completion for complete_id.
- complete_id  in  5  ID being completed.
- gateway_req  out  SOURCES  request level to PLIC; bit 0 always 0.
- edge_overflow  out  SOURCES  sticky flag: edge arrived while counter saturated.

Behaviour:
- Reset: all synchroniser and previous-value flops 0; every source IDLE; edge counters 0; gateway_req = 0; edge_overflow = 0. Reset mid-operation discards all outstanding requests and counts.
- Synchroniser: irq_in[i] passes through SYNC_STAGES flops to give s[i]. A one-flop delayed copy p[i] gives rise[i] = s[i] & ~p[i].
- Per-source FSM (i = 1..SOURCES-1), three states:
  - IDLE (req 0) -> REQ when trig[i]. In level mode, trig = s[i]. In edge mode, trig = (cnt[i] != 0) | rise[i].
  - REQ (req 1) -> INFLIGHT on claim_valid & claim_id == i.
  - REQ -> IDLE in level mode if s[i] == 0 and no matching claim this cycle (request retracted).
  - INFLIGHT (req 0) -> IDLE on complete_valid & complete_id == i.
- gateway_req[i] = 1 exactly in REQ; it is registered.
- Latency: irq_in rising to gateway_req high = SYNC_STAGES+1 cycles (3 at default).
- Edge counter, edge mode only:
  - +1 on rise[i] unless the same cycle consumes it via IDLE->REQ.
  - -1 on IDLE->REQ when trig came from cnt (no rise in that cycle).
  - Rise and IDLE->REQ in the same cycle: counter unchanged, edge consumed directly.
  - Saturates at max. A rise at max that is not consumed sets edge_overflow[i] (sticky until rst).
- Counter forced to 0 while irq_edge_mode[i] = 0. A mode change takes effect on the FSM at the next IDLE evaluation.
- Completion for a source not in INFLIGHT is ignored; a claim for a source not in REQ is ignored. claim_id or complete_id of 0 or >= SOURCES is ignored.
- Claim and complete with the same ID in the same cycle while in REQ: the claim is applied, the completion is ignored.
- Claim and complete with different IDs in the same cycle: both applied independently.
- INFLIGHT -> IDLE -> REQ needs a minimum of one cycle in IDLE. Re-request occurs the cycle after IDLE if trig still holds.
- Bit 0 of gateway_req and edge_overflow tied to 0.

Test Plan:
- Level source 3: irq_in[3] 0->1 at cycle 10 -> gateway_req[3]=1 at cycle 13. claim_id=3 at cycle 15 -> req 0 at cycle 16. Completion at cycle 20 while line still high -> req 1 again at cycle 22.
- Level retract: irq_in[5] high for 4 cycles, no claim -> gateway_req[5] high for 4 cycles then 0, FSM back in IDLE, no INFLIGHT entry.
- Edge source 7 burst: 5 single-cycle pulses spaced 3 cycles apart while INFLIGHT -> cnt=5. Each subsequent claim+complete pair re-raises req; exactly 5 further requests issued, then req stays 0.
- Edge overflow: 9 pulses to source 9 while INFLIGHT (max 7) -> cnt=7, edge_overflow[9]=1, remains 1 after subsequent completions until rst.
- Simultaneous: source 4 in REQ gets claim_valid and complete_valid with id 4 in the same cycle -> state INFLIGHT, req 0. A later lone completion for 4 returns it to IDLE. Completion for IDLE source 6 -> no change.
- Reset mid-op: sources 2 (REQ), 3 (INFLIGHT) and 7 (cnt=4) active, assert rst one cycle -> next cycle gateway_req=0, edge_overflow=0, all counts 0. No request appears until a fresh trigger.
